// File: rtl/lc3_pc_ras_if.sv
// Control/status bundle between the datapath controller (master) and the
// PC + return-address-stack block (slave). main_bus stays a plain inout on the
// block because it is a shared tristate net, not a point-to-point signal.
// Optional trace signals exist only when LC3_PC_TRACE_EN is defined.
interface lc3_pc_ras_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Controller -> PC block
  logic [WIDTH-1:0] ADDR;
  logic             GatePC;
  logic             LDPC;
  logic [1:0]       PCMUX;
  logic             PUSH;
  logic             POP;

  // PC block -> controller
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] RAS_TOP;
  logic [CntW-1:0]  RAS_CNT;
  logic             RAS_EMPTY;
  logic             RAS_FULL;
  logic             RAS_ERR;
`ifdef LC3_PC_TRACE_EN
  logic [WIDTH-1:0] PREV_PC;
  logic [15:0]      DISC_CNT;
`endif

  modport master (
    output ADDR, GatePC, LDPC, PCMUX, PUSH, POP,
`ifdef LC3_PC_TRACE_EN
    input  PREV_PC, DISC_CNT,
`endif
    input  PC, RAS_TOP, RAS_CNT, RAS_EMPTY, RAS_FULL, RAS_ERR
  );

  modport slave (
    input  ADDR, GatePC, LDPC, PCMUX, PUSH, POP,
`ifdef LC3_PC_TRACE_EN
    output PREV_PC, DISC_CNT,
`endif
    output PC, RAS_TOP, RAS_CNT, RAS_EMPTY, RAS_FULL, RAS_ERR
  );
endinterface

// File: rtl/lc3_pc_ras.sv
// LC-3 program counter with next-PC mux, tristate drive onto main_bus and a
// DEPTH-entry circular return-address stack (RAS) for call/return linkage.
// Optional feature macro: LC3_PC_TRACE_EN adds PREV_PC / DISC_CNT tracking of
// the last discontinuous (non PC+1) load.
//
// Stack organisation: sp_q points at the next slot to write; the top entry is
// sp_q-1 (mod DEPTH). On overflow the write lands on the oldest entry, so the
// ring silently keeps the newest DEPTH return addresses.
module lc3_pc_ras #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = 'h0200
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] main_bus,
  lc3_pc_ras_if.slave      ctl
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] MuxInc  = 2'b00;
  localparam logic [1:0] MuxBus  = 2'b01;
  localparam logic [1:0] MuxAddr = 2'b10;
  localparam logic [1:0] MuxRas  = 2'b11;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [DEPTH];
  logic [PtrW-1:0]  sp_q, sp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [PtrW-1:0]  top_idx;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] pc_mux;
  logic             ras_empty;
  logic             ras_full;
  logic             wr_en;
  logic [PtrW-1:0]  wr_idx;

  assign top_idx   = sp_q - 1'b1;
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntW'(DEPTH));

  // Next-PC selection; PC+1 wraps naturally at the WIDTH boundary.
  always_comb begin
    pc_mux = pc_q + 1'b1;
    unique case (ctl.PCMUX)
      MuxInc:  pc_mux = pc_q + 1'b1;
      MuxBus:  pc_mux = main_bus;
      MuxAddr: pc_mux = ctl.ADDR;
      MuxRas:  pc_mux = ras_top;
      default: pc_mux = pc_q + 1'b1;
    endcase
  end

  // PC load and stack pointer/count/error update; all qualified by LDPC.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (ctl.LDPC) begin
      pc_d = pc_mux;
      if (ctl.PUSH && ctl.POP && !ras_empty) begin
        // Call-replaces-return: overwrite top in place, depth unchanged.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (ctl.PUSH) begin
        wr_en  = 1'b1;
        wr_idx = sp_q;
        sp_d   = sp_q + 1'b1;
        if (ras_full) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (ctl.POP) begin
        if (ras_empty) begin
          err_d = 1'b1;
        end else begin
          sp_d  = sp_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // PC, pointer, count and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage; the pushed value is always the PC before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (wr_en) begin
      ras_q[wr_idx] <= pc_q;
    end
  end

`ifdef LC3_PC_TRACE_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [15:0]      disc_q, disc_d;

  // Record the PC we jumped away from on every non-sequential load.
  always_comb begin
    prev_d = prev_q;
    disc_d = disc_q;
    if (ctl.LDPC && (ctl.PCMUX != MuxInc)) begin
      prev_d = pc_q;
      if (disc_q != 16'hFFFF) begin
        disc_d = disc_q + 16'd1;
      end
    end
  end

  // Trace registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= RESET_VEC;
      disc_q <= '0;
    end else begin
      prev_q <= prev_d;
      disc_q <= disc_d;
    end
  end

  assign ctl.PREV_PC  = prev_q;
  assign ctl.DISC_CNT = disc_q;
`endif

  assign main_bus      = ctl.GatePC ? pc_q : {WIDTH{1'bz}};
  assign ctl.PC        = pc_q;
  assign ctl.RAS_TOP   = ras_top;
  assign ctl.RAS_CNT   = cnt_q;
  assign ctl.RAS_EMPTY = ras_empty;
  assign ctl.RAS_FULL  = ras_full;
  assign ctl.RAS_ERR   = err_q;

endmodule

// File: tb/tb_lc3_pc_ras.sv
// Self-checking bench for lc3_pc_ras: directed scenarios followed by random
// stimulus compared against a queue-based model of the return-address stack.
module tb_lc3_pc_ras;
  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst;
  wire  [15:0] main_bus;
  logic        bus_oe;
  logic [15:0] bus_drv;

  lc3_pc_ras_if #(.WIDTH(16), .DEPTH(Depth)) ifc ();

  lc3_pc_ras #(.WIDTH(16), .DEPTH(Depth), .RESET_VEC(16'h0200)) dut (
    .clk      (clk),
    .rst      (rst),
    .main_bus (main_bus),
    .ctl      (ifc.slave)
  );

  assign main_bus = bus_oe ? bus_drv : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] q[$];
  logic        m_err;
  logic [15:0] m_prev;
  logic [15:0] m_disc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 16'h0200;
    q.delete();
    m_err  = 1'b0;
    m_prev = 16'h0200;
    m_disc = 16'h0000;
  endtask

  task automatic check_all();
    check_val("pc", 32'(ifc.PC), 32'(m_pc));
    check_val("cnt", 32'(ifc.RAS_CNT), q.size());
    check_val("empty", 32'(ifc.RAS_EMPTY), 32'(q.size() == 0));
    check_val("full", 32'(ifc.RAS_FULL), 32'(q.size() == Depth));
    check_val("err", 32'(ifc.RAS_ERR), 32'(m_err));
    if (q.size() > 0) check_val("top", 32'(ifc.RAS_TOP), 32'(q[q.size()-1]));
`ifdef LC3_PC_TRACE_EN
    check_val("prev_pc", 32'(ifc.PREV_PC), 32'(m_prev));
    check_val("disc_cnt", 32'(ifc.DISC_CNT), 32'(m_disc));
`endif
  endtask

  // One clock: apply inputs, check bus drive, advance model, check state.
  task automatic step(input logic ld, input logic [1:0] mux, input logic push,
                      input logic pop, input logic [15:0] addr, input logic [15:0] busv,
                      input logic gate);
    logic [15:0] nxt;
    logic [15:0] bus_val;
    ifc.LDPC   = ld;
    ifc.PCMUX  = mux;
    ifc.PUSH   = push;
    ifc.POP    = pop;
    ifc.ADDR   = addr;
    ifc.GatePC = gate;
    bus_oe     = !gate;
    bus_drv    = busv;
    #1;
    if (gate) check_val("bus_drive", 32'(main_bus), 32'(m_pc));
    bus_val = gate ? m_pc : busv;
    case (mux)
      2'b00:   nxt = m_pc + 16'd1;
      2'b01:   nxt = bus_val;
      2'b10:   nxt = addr;
      default: nxt = (q.size() > 0) ? q[q.size()-1] : 16'h0000;
    endcase
    if (ld) begin
      if (push && pop && q.size() > 0) begin
        q[q.size()-1] = m_pc;
      end else if (push) begin
        if (q.size() == Depth) begin
          void'(q.pop_front());
          m_err = 1'b1;
        end
        q.push_back(m_pc);
      end else if (pop) begin
        if (q.size() == 0) m_err = 1'b1;
        else void'(q.pop_back());
      end
      if (mux != 2'b00) begin
        m_prev = m_pc;
        if (m_disc != 16'hFFFF) m_disc = m_disc + 16'd1;
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse applied between edges with a load pending.
  task automatic do_reset();
    ifc.LDPC  = 1'b1;
    ifc.PUSH  = 1'b1;
    ifc.PCMUX = 2'b10;
    ifc.ADDR  = 16'h7777;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_val("rst_pc", 32'(ifc.PC), 32'h0200);
    check_val("rst_cnt", 32'(ifc.RAS_CNT), 32'd0);
    check_val("rst_err", 32'(ifc.RAS_ERR), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    ifc.LDPC = 1'b0;
    ifc.PUSH = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus_oe = 1'b1;
    bus_drv = 16'h0000;
    ifc.LDPC = 1'b0; ifc.PCMUX = 2'b00; ifc.PUSH = 1'b0; ifc.POP = 1'b0;
    ifc.ADDR = 16'h0000; ifc.GatePC = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("init_top", 32'(ifc.RAS_TOP), 32'h0);
    check_all();
    rst = 1'b1;
    #1;

    // 1: reset mid-operation after pushes and an error
    step(1, 2'b10, 1, 0, 16'h1111, 16'h0, 0);
    step(1, 2'b00, 1, 0, 16'h0, 16'h0, 1);
    do_reset();
    check_val("rst_top", 32'(ifc.RAS_TOP), 32'h0);

    // 2: sequential wrap and bus behaviour
    step(1, 2'b01, 0, 0, 16'h0, 16'hFFFF, 0);
    check_val("ld_bus", 32'(ifc.PC), 32'hFFFF);
    step(1, 2'b00, 0, 0, 16'h0, 16'h1234, 0);
    check_val("wrap", 32'(ifc.PC), 32'h0000);
    step(0, 2'b10, 1, 1, 16'h9999, 16'h5A5A, 0);
    check_val("bus_release", 32'(main_bus), 32'h5A5A);
    check_val("no_ld", 32'(ifc.PC), 32'h0000);

    // 3: call / return
    step(1, 2'b10, 0, 0, 16'h3000, 16'h0, 0);
    step(1, 2'b10, 1, 0, 16'h4000, 16'h0, 1);
    check_val("call_pc", 32'(ifc.PC), 32'h4000);
    check_val("call_top", 32'(ifc.RAS_TOP), 32'h3000);
    check_val("call_cnt", 32'(ifc.RAS_CNT), 32'd1);
    step(1, 2'b11, 0, 1, 16'h0, 16'h0, 0);
    check_val("ret_pc", 32'(ifc.PC), 32'h3000);
    check_val("ret_empty", 32'(ifc.RAS_EMPTY), 32'd1);

    // 4: overflow
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1, 2'b10, 0, 0, 16'(k), 16'h0, 0);
      step(1, 2'b00, 1, 0, 16'h0, 16'h0, 0);
    end
    check_val("ovf_cnt", 32'(ifc.RAS_CNT), 32'd4);
    check_val("ovf_err", 32'(ifc.RAS_ERR), 32'd1);
    for (int k = 5; k >= 2; k--) begin
      step(1, 2'b11, 0, 1, 16'h0, 16'h0, 0);
      check_val("ovf_pop", 32'(ifc.PC), 32'(k));
    end

    // 5: underflow, then simultaneous push+pop
    do_reset();
    step(1, 2'b00, 0, 1, 16'h0, 16'h0, 0);
    check_val("udf_err", 32'(ifc.RAS_ERR), 32'd1);
    check_val("udf_cnt", 32'(ifc.RAS_CNT), 32'd0);
    step(1, 2'b10, 0, 0, 16'h0010, 16'h0, 0);
    step(1, 2'b10, 1, 0, 16'h0020, 16'h0, 0);
    step(1, 2'b10, 1, 0, 16'h0030, 16'h0, 0);
    step(1, 2'b00, 1, 1, 16'h0, 16'h0, 0);
    check_val("pp_top", 32'(ifc.RAS_TOP), 32'h0030);
    check_val("pp_cnt", 32'(ifc.RAS_CNT), 32'd2);

    // 6: trace (checked in check_all when enabled)
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 2'b00, 0, 0, 16'h0, 16'h0, 0);
    check_val("trace_pc", 32'(ifc.PC), 32'h0210);
    step(1, 2'b01, 0, 0, 16'h0, 16'h0500, 0);
`ifdef LC3_PC_TRACE_EN
    check_val("trace_prev", 32'(ifc.PREV_PC), 32'h0210);
    check_val("trace_disc", 32'(ifc.DISC_CNT), 32'd1);
    step(1, 2'b00, 0, 0, 16'h0, 16'h0, 0);
    check_val("trace_hold", 32'(ifc.DISC_CNT), 32'd1);
`endif

    // Random phase
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] mux;
      mux = 2'($urandom_range(0, 3));
      // Top of an empty stack is a stale value the model does not track.
      if (mux == 2'b11 && q.size() == 0) mux = 2'b00;
      step(($urandom_range(0, 3) != 0), mux, ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 3), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)));
      if (n == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
